// File: rtl/axi_slave_port.sv
// Driver-side register/memory access port for the USB host controller.
// Arbitrates simplified AXI-lite reads and writes onto the CSR bank or the 128-bit descriptor memory.
module axi_slave_port #(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned Data_W         = 32,
   parameter int unsigned MEM_ADDR_WIDTH = 6,
   parameter int unsigned MEM_NUM_COL    = 4,
   parameter int unsigned MEM_COL_WIDTH  = 32,
   parameter int unsigned MEM_DATA_WIDTH = MEM_COL_WIDTH * MEM_NUM_COL,
   parameter int unsigned NUM_REGS       = 6
) (
   input  logic                        Clk_axi,
   input  logic                        Rst,
   input  logic [ADDR_W-1:0]           Write_Address_axi,
   input  logic [Data_W-1:0]           Write_Data_axi,
   input  logic [3:0]                  Write_Strobe,
   input  logic [2:0]                  W_Prot,
   input  logic                        Write_Valid,
   output logic                        Write_Ready,
   output logic                        W_Error,
   input  logic [ADDR_W-1:0]           Read_Address_axi,
   input  logic [2:0]                  R_Prot,
   input  logic                        R_Valid_Address,
   output logic                        R_Ready_Address,
   input  logic                        Read_Ready,
   output logic                        Valid_Data_R,
   output logic                        R_Error,
   output logic [Data_W-1:0]           Read_Data_axi,
   output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
   output logic [4*MEM_NUM_COL-1:0]    mem_byte_we,
   output logic [MEM_DATA_WIDTH-1:0]   mem_wdata,
   output logic                        mem_rd_en,
   input  logic [MEM_DATA_WIDTH-1:0]   mem_rdata,
   output logic [2:0]                  reg_addr,
   output logic                        reg_we,
   output logic [3:0]                  reg_be,
   output logic [31:0]                 reg_wdata,
   output logic                        reg_re,
   input  logic [31:0]                 reg_rdata
);

   localparam int unsigned STRB_W = 4;
   localparam int unsigned BE_W   = STRB_W * MEM_NUM_COL;

   typedef enum logic [2:0] {IDLE, W_EXEC, W_RESP, R_ADDR, R_WAIT, R_DATA} state_t;

   state_t                      state_q, state_d;
   logic                        wr_prio_q, wr_prio_d;
   logic                        is_reg_q, is_reg_d;
   logic                        err_q, err_d;
   logic [1:0]                  col_q, col_d;
   logic [31:0]                 reg_rdata_q, reg_rdata_d;

   logic                        write_ready_d, w_error_d, r_ready_address_d;
   logic                        valid_data_r_d, r_error_d, mem_rd_en_d, reg_we_d, reg_re_d;
   logic [Data_W-1:0]           read_data_d;
   logic [MEM_ADDR_WIDTH-1:0]   mem_addr_d;
   logic [BE_W-1:0]             mem_byte_we_d;
   logic [MEM_DATA_WIDTH-1:0]   mem_wdata_d;
   logic [2:0]                  reg_addr_d;
   logic [3:0]                  reg_be_d;
   logic [31:0]                 reg_wdata_d;

   logic                        wr_is_reg, rd_is_reg, wr_err, rd_err, grant_w, grant_r;
   logic [1:0]                  wr_col;
   logic [MEM_COL_WIDTH-1:0]    sel_word;
   logic                        unused_bits;

   // Address bits above 8 and the protection fields carry no meaning here
   assign unused_bits = ^{W_Prot, R_Prot, Write_Address_axi[ADDR_W-1:9], Read_Address_axi[ADDR_W-1:9]};

   assign wr_is_reg = Write_Address_axi[8];
   assign rd_is_reg = Read_Address_axi[8];
   assign wr_col    = Write_Address_axi[1:0];
   assign wr_err    = (wr_is_reg && (32'(Write_Address_axi[2:0]) >= NUM_REGS)) || (Write_Strobe == '0);
   assign rd_err    = rd_is_reg && (32'(Read_Address_axi[2:0]) >= NUM_REGS);
   assign grant_w   = Write_Valid && (!R_Valid_Address || wr_prio_q);
   assign grant_r   = R_Valid_Address && !grant_w;
   assign sel_word  = mem_rdata[MEM_COL_WIDTH*32'(col_q) +: MEM_COL_WIDTH];

   // Next state plus next values of every registered output
   always_comb begin
      state_d           = state_q;
      wr_prio_d         = wr_prio_q;
      is_reg_d          = is_reg_q;
      err_d             = err_q;
      col_d             = col_q;
      reg_rdata_d       = reg_rdata_q;
      write_ready_d     = 1'b0;
      w_error_d         = 1'b0;
      r_ready_address_d = 1'b0;
      valid_data_r_d    = 1'b0;
      r_error_d         = 1'b0;
      mem_rd_en_d       = 1'b0;
      reg_we_d          = 1'b0;
      reg_re_d          = 1'b0;
      mem_byte_we_d     = '0;
      reg_be_d          = '0;
      read_data_d       = Read_Data_axi;
      mem_addr_d        = mem_addr;
      mem_wdata_d       = mem_wdata;
      reg_addr_d        = reg_addr;
      reg_wdata_d       = reg_wdata;

      case (state_q)
         IDLE: begin
            if (grant_w) begin
               state_d     = W_EXEC;
               wr_prio_d   = 1'b0;
               is_reg_d    = wr_is_reg;
               err_d       = wr_err;
               col_d       = wr_col;
               mem_addr_d  = MEM_ADDR_WIDTH'(Write_Address_axi[7:2]);
               mem_wdata_d = MEM_DATA_WIDTH'({MEM_NUM_COL{Write_Data_axi}});
               reg_addr_d  = Write_Address_axi[2:0];
               reg_wdata_d = 32'(Write_Data_axi);
               if (!wr_err && wr_is_reg) begin
                  reg_we_d = 1'b1;
                  reg_be_d = Write_Strobe;
               end else if (!wr_err) begin
                  mem_byte_we_d[STRB_W*32'(wr_col) +: STRB_W] = Write_Strobe;
               end
            end else if (grant_r) begin
               state_d           = R_ADDR;
               wr_prio_d         = 1'b1;
               is_reg_d          = rd_is_reg;
               err_d             = rd_err;
               col_d             = Read_Address_axi[1:0];
               mem_addr_d        = MEM_ADDR_WIDTH'(Read_Address_axi[7:2]);
               reg_addr_d        = Read_Address_axi[2:0];
               r_ready_address_d = 1'b1;
               reg_re_d          = !rd_err && rd_is_reg;
               mem_rd_en_d       = !rd_err && !rd_is_reg;
            end
         end
         W_EXEC: begin
            state_d       = W_RESP;
            write_ready_d = 1'b1;
            w_error_d     = err_q;
         end
         W_RESP: state_d = IDLE;
         R_ADDR: begin
            state_d     = R_WAIT;
            reg_rdata_d = reg_rdata;
         end
         R_WAIT: begin
            state_d        = R_DATA;
            valid_data_r_d = 1'b1;
            r_error_d      = err_q;
            if (err_q)         read_data_d = '0;
            else if (is_reg_q) read_data_d = Data_W'(reg_rdata_q);
            else               read_data_d = Data_W'(sel_word);
         end
         R_DATA: begin
            if (Read_Ready) begin
               state_d = IDLE;
            end else begin
               valid_data_r_d = 1'b1;
               r_error_d      = R_Error;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk_axi or negedge Rst) begin
      if (!Rst) begin
         state_q         <= IDLE;
         wr_prio_q       <= 1'b1;
         is_reg_q        <= 1'b0;
         err_q           <= 1'b0;
         col_q           <= '0;
         reg_rdata_q     <= '0;
         Write_Ready     <= 1'b0;
         W_Error         <= 1'b0;
         R_Ready_Address <= 1'b0;
         Valid_Data_R    <= 1'b0;
         R_Error         <= 1'b0;
         Read_Data_axi   <= '0;
         mem_addr        <= '0;
         mem_byte_we     <= '0;
         mem_wdata       <= '0;
         mem_rd_en       <= 1'b0;
         reg_addr        <= '0;
         reg_we          <= 1'b0;
         reg_be          <= '0;
         reg_wdata       <= '0;
         reg_re          <= 1'b0;
      end else begin
         state_q         <= state_d;
         wr_prio_q       <= wr_prio_d;
         is_reg_q        <= is_reg_d;
         err_q           <= err_d;
         col_q           <= col_d;
         reg_rdata_q     <= reg_rdata_d;
         Write_Ready     <= write_ready_d;
         W_Error         <= w_error_d;
         R_Ready_Address <= r_ready_address_d;
         Valid_Data_R    <= valid_data_r_d;
         R_Error         <= r_error_d;
         Read_Data_axi   <= read_data_d;
         mem_addr        <= mem_addr_d;
         mem_byte_we     <= mem_byte_we_d;
         mem_wdata       <= mem_wdata_d;
         mem_rd_en       <= mem_rd_en_d;
         reg_addr        <= reg_addr_d;
         reg_we          <= reg_we_d;
         reg_be          <= reg_be_d;
         reg_wdata       <= reg_wdata_d;
         reg_re          <= reg_re_d;
      end
   end

endmodule

// File: tb/tb_axi_slave_port.sv
// Self-checking bench for axi_slave_port: directed cases plus random traffic against a word-level model.
module tb_axi_slave_port;

   logic         Clk_axi = 1'b0;
   logic         Rst;
   logic [31:0]  Write_Address_axi, Write_Data_axi, Read_Address_axi;
   logic [3:0]   Write_Strobe;
   logic [2:0]   W_Prot, R_Prot;
   logic         Write_Valid, R_Valid_Address, Read_Ready;
   logic         Write_Ready, W_Error, R_Ready_Address, Valid_Data_R, R_Error;
   logic [31:0]  Read_Data_axi;
   logic [5:0]   mem_addr;
   logic [15:0]  mem_byte_we;
   logic [127:0] mem_wdata, mem_rdata;
   logic         mem_rd_en;
   logic [2:0]   reg_addr;
   logic         reg_we, reg_re;
   logic [3:0]   reg_be;
   logic [31:0]  reg_wdata, reg_rdata;

   int total = 0;
   int bad   = 0;

   // Environment storage driven by the DUT's enables
   logic [127:0] env_mem  [0:63];
   logic [31:0]  env_regs [0:5];
   // Reference model: one entry per addressable 32-bit word
   logic [31:0]  ref_mem  [0:255];
   logic [31:0]  ref_regs [0:5];

   always #5 Clk_axi = ~Clk_axi;

   axi_slave_port dut (
      .Clk_axi(Clk_axi), .Rst(Rst),
      .Write_Address_axi(Write_Address_axi), .Write_Data_axi(Write_Data_axi),
      .Write_Strobe(Write_Strobe), .W_Prot(W_Prot), .Write_Valid(Write_Valid),
      .Write_Ready(Write_Ready), .W_Error(W_Error),
      .Read_Address_axi(Read_Address_axi), .R_Prot(R_Prot),
      .R_Valid_Address(R_Valid_Address), .R_Ready_Address(R_Ready_Address),
      .Read_Ready(Read_Ready), .Valid_Data_R(Valid_Data_R), .R_Error(R_Error),
      .Read_Data_axi(Read_Data_axi),
      .mem_addr(mem_addr), .mem_byte_we(mem_byte_we), .mem_wdata(mem_wdata),
      .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
      .reg_addr(reg_addr), .reg_we(reg_we), .reg_be(reg_be), .reg_wdata(reg_wdata),
      .reg_re(reg_re), .reg_rdata(reg_rdata)
   );

   always @(posedge Clk_axi) begin
      if (mem_rd_en) mem_rdata <= env_mem[mem_addr];
      for (int b = 0; b < 16; b++)
         if (mem_byte_we[b]) env_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (reg_we && reg_addr < 3'd6)
         for (int b = 0; b < 4; b++)
            if (reg_be[b]) env_regs[reg_addr][8*b +: 8] <= reg_wdata[8*b +: 8];
   end

   assign reg_rdata = (reg_addr < 3'd6) ? env_regs[reg_addr] : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      logic       is_reg, err;
      logic [2:0] idx;
      logic [5:0] row;
      logic [1:0] col;
      logic [15:0] exp_we;
      is_reg = addr[8];
      idx    = addr[2:0];
      row    = addr[7:2];
      col    = addr[1:0];
      err    = (is_reg && idx >= 3'd6) || (strb == 4'h0);
      exp_we = (!err && !is_reg) ? (16'(strb) << (4*col)) : 16'h0;
      @(posedge Clk_axi); #1;
      Write_Address_axi = addr;
      Write_Data_axi    = data;
      Write_Strobe      = strb;
      W_Prot            = 3'($urandom);
      Write_Valid       = 1'b1;
      @(posedge Clk_axi); #1;
      Write_Valid = 1'b0;
      check("w_byte_we", mem_byte_we, exp_we);
      check("w_reg_we", reg_we, !err && is_reg);
      check("w_reg_be", reg_be, (!err && is_reg) ? strb : 4'h0);
      check("w_ready_early", Write_Ready, 1'b0);
      if (!err && !is_reg) begin
         check("w_mem_addr", mem_addr, row);
         check("w_mem_wdata", mem_wdata, {4{data}});
      end
      if (!err && is_reg) begin
         check("w_reg_addr", reg_addr, idx);
         check("w_reg_wdata", reg_wdata, data);
      end
      @(posedge Clk_axi); #1;
      check("w_ready", Write_Ready, 1'b1);
      check("w_error", W_Error, err);
      check("w_enables_off", {reg_we, mem_byte_we}, 17'h0);
      @(posedge Clk_axi); #1;
      check("w_ready_drop", Write_Ready, 1'b0);
      if (!err) begin
         if (is_reg) ref_regs[idx] = merge(ref_regs[idx], data, strb);
         else        ref_mem[{row, col}] = merge(ref_mem[{row, col}], data, strb);
      end
   endtask

   task automatic do_read(input logic [31:0] addr, input int hold);
      logic        is_reg, err;
      logic [2:0]  idx;
      logic [31:0] exp_data;
      is_reg   = addr[8];
      idx      = addr[2:0];
      err      = is_reg && idx >= 3'd6;
      exp_data = err ? 32'h0 : (is_reg ? ref_regs[idx] : ref_mem[addr[7:0]]);
      @(posedge Clk_axi); #1;
      Read_Address_axi = addr;
      R_Prot           = 3'($urandom);
      R_Valid_Address  = 1'b1;
      Read_Ready       = 1'b0;
      @(posedge Clk_axi); #1;
      R_Valid_Address = 1'b0;
      check("r_addr_ready", R_Ready_Address, 1'b1);
      check("r_mem_rd_en", mem_rd_en, !err && !is_reg);
      check("r_reg_re", reg_re, !err && is_reg);
      check("r_valid_early", Valid_Data_R, 1'b0);
      @(posedge Clk_axi); #1;
      check("r_addr_ready_drop", R_Ready_Address, 1'b0);
      check("r_valid_wait", Valid_Data_R, 1'b0);
      @(posedge Clk_axi); #1;
      check("r_valid", Valid_Data_R, 1'b1);
      check("r_error", R_Error, err);
      check("r_data", Read_Data_axi, exp_data);
      for (int i = 0; i < hold; i++) begin
         @(posedge Clk_axi); #1;
         check("r_valid_hold", Valid_Data_R, 1'b1);
         check("r_data_hold", Read_Data_axi, exp_data);
      end
      Read_Ready = 1'b1;
      @(posedge Clk_axi); #1;
      Read_Ready = 1'b0;
      check("r_valid_clear", Valid_Data_R, 1'b0);
      check("r_data_kept", Read_Data_axi, exp_data);
   endtask

   initial begin
      bit          grants[$];
      logic [31:0] a, d;
      logic [3:0]  s;
      logic [31:0] w;

      for (int r = 0; r < 64; r++)
         for (int c = 0; c < 4; c++) begin
            w = $urandom;
            ref_mem[r*4 + c]      = w;
            env_mem[r][32*c +: 32] = w;
         end
      for (int i = 0; i < 6; i++) begin
         w = $urandom;
         ref_regs[i] = w;
         env_regs[i] = w;
      end
      mem_rdata = '0;
      Rst = 1'b0;
      Write_Address_axi = '0; Write_Data_axi = '0; Write_Strobe = '0; W_Prot = '0;
      Write_Valid = 1'b0; Read_Address_axi = '0; R_Prot = '0;
      R_Valid_Address = 1'b0; Read_Ready = 1'b0;
      #3;
      check("rst_outputs", {Write_Ready, W_Error, R_Ready_Address, Valid_Data_R, R_Error,
                            mem_byte_we, mem_rd_en, reg_we, reg_re}, 24'h0);
      check("rst_rdata", Read_Data_axi, 32'h0);
      #9 Rst = 1'b1;

      // Simultaneous requests: round-robin starting with write
      @(posedge Clk_axi); #1;
      Write_Address_axi = 32'h020; Write_Data_axi = 32'h1234_5678; Write_Strobe = 4'hF;
      Read_Address_axi  = 32'h031;
      Write_Valid = 1'b1; R_Valid_Address = 1'b1; Read_Ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         @(posedge Clk_axi); #1;
         if (mem_byte_we != 16'h0) grants.push_back(1'b1);
         if (R_Ready_Address)      grants.push_back(1'b0);
      end
      Write_Valid = 1'b0; R_Valid_Address = 1'b0;
      repeat (6) @(posedge Clk_axi);
      #1 Read_Ready = 1'b0;
      check("arb_grant_count", grants.size() >= 4, 1'b1);
      for (int i = 0; i < 4 && i < grants.size(); i++)
         check("arb_order", grants[i], (i % 2) == 0);
      ref_mem[8'h20] = 32'h1234_5678;
      do_read(32'h020, 0);

      // Asynchronous reset in the middle of a write
      @(posedge Clk_axi); #1;
      Write_Address_axi = 32'h010; Write_Data_axi = 32'hCAFE_F00D; Write_Strobe = 4'hF;
      Write_Valid = 1'b1;
      @(posedge Clk_axi); #1;
      Write_Valid = 1'b0;
      check("rst_mid_we_before", mem_byte_we, 16'h000F);
      #1 Rst = 1'b0;
      #1;
      check("rst_mid_we", mem_byte_we, 16'h0);
      check("rst_mid_ready", Write_Ready, 1'b0);
      #1 Rst = 1'b1;
      @(posedge Clk_axi); #1;
      check("rst_no_resp", Write_Ready, 1'b0);
      do_read(32'h010, 0);

      // Directed memory and register accesses
      do_write(32'h008, 32'hA5A5_0001, 4'hF);
      do_read(32'h008, 0);
      for (int i = 0; i < 4; i++)
         do_write(32'h00C + 32'(i), 32'h1111_0000 + 32'(i), 4'hF);
      do_read(32'h00E, 3);
      do_write(32'h2_0104, 32'h1, 4'h3);
      do_read(32'h2_0104, 1);
      do_write(32'h107, 32'h5555_AAAA, 4'hF);
      do_read(32'h106, 0);
      do_write(32'h010, 32'h7777_7777, 4'h0);
      do_read(32'h010, 0);

      // Random traffic
      for (int n = 0; n < 60; n++) begin
         a = $urandom & 32'hFFFF_FE00;
         if ($urandom_range(0, 9) < 6) a = a | 32'($urandom_range(0, 255));
         else                          a = a | 32'h100 | 32'($urandom_range(0, 7));
         d = $urandom;
         s = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
         if ($urandom_range(0, 1) == 1) do_write(a, d, s);
         else                           do_read(a, $urandom_range(0, 2));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
